mtl_event_master: RTL and testbench
===================================

MTL_EVENT_MASTER -- requirements
Module: mtl_event_master

Interface
REQ-001 Parameter DEPTH, default 4: event FIFO depth in entries; power of two, at least 2.
REQ-002 Parameter TARGET_ADDR, default 1'b0: Avalon address driven on every write.
REQ-003 clk  input  1  single system clock; all logic on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 event_valid  input  1  one-cycle event strobe from the producer (touch/slide logic).
REQ-006 event_code  input  8  event payload; sampled when event_valid=1.
REQ-007 event_ready  output  1  high when the FIFO is not full; advisory only, the producer does not wait on it.
REQ-008 avm_m0_write  output  1  Avalon-MM master write request.
REQ-009 avm_m0_address  output  1  Avalon-MM address, always TARGET_ADDR.
REQ-010 avm_m0_writedata  output  8  Avalon-MM write data.
REQ-011 avm_m0_waitrequest  input  1  slave stall; the transfer completes on a cycle with write=1 and waitrequest=0.
REQ-012 drop_count  output  8  number of events lost to overflow; saturates at 255.

Function
REQ-013 Push: an event is pushed when event_valid=1 and the FIFO is not full at that edge; the full flag is taken before any same-cycle pop.
REQ-014 Overflow: event_valid=1 while the FIFO is full drops the event and increments drop_count by 1, holding at 8'hFF.
REQ-015 Simultaneous push and pop when the FIFO is not full: both take effect and occupancy is unchanged.
REQ-016 FSM states: IDLE and WRITE, encoded as a 1-bit enum.
REQ-017 IDLE: avm_m0_write=0; go to WRITE on the edge after the FIFO becomes non-empty.
REQ-018 WRITE: avm_m0_write=1 and avm_m0_writedata equals the FIFO head; address and data are registered and do not change while waitrequest=1.
REQ-019 Completion edge (WRITE and waitrequest=0): pop the head; stay in WRITE with the next head if occupancy after the pop is at least 1, otherwise go to IDLE.
REQ-020 Back-to-back writes: consecutive completions need no idle cycle between them.
REQ-021 Latency: an event pushed into an empty FIFO at edge N from IDLE produces avm_m0_write=1 with its code in the cycle after edge N+1.
REQ-022 Ordering: events are written in strict arrival order, with no duplication and no loss other than REQ-014 drops.
REQ-023 Pointer arithmetic: read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH; occupancy is a separate counter of log2(DEPTH)+1 bits.
REQ-024 event_ready = (occupancy != DEPTH), combinational from registered state.
REQ-025 avm_m0_write, avm_m0_address and avm_m0_writedata are driven directly from registers.

Reset
REQ-026 While reset=0: state=IDLE, pointers=0, occupancy=0, drop_count=0, avm_m0_write=0, avm_m0_writedata=0, avm_m0_address=TARGET_ADDR, event_ready=1.
REQ-027 Reset asserted during WRITE aborts the transfer immediately; FIFO contents are discarded, not replayed.
REQ-028 After release, the first edge already accepts events.

Structure
REQ-029 A shared package mtl_pkg holds the FSM state typedef, EVENT_W=8 and DROP_CNT_W=8.
REQ-030 A single sub-module, mtl_event_fifo (parameterised by DEPTH and EVENT_W, with push/pop/full/empty/head ports), holds the storage; the FSM and drop counter live in the top module.

Verification
REQ-031 Single event 8'h01 with waitrequest=0 -> exactly one write with data 8'h01 and address 0, a one-cycle write pulse, then IDLE.
REQ-032 Events 8'hA1, 8'hA2, 8'hA3 on consecutive cycles, with waitrequest held high for 3 cycles on the first write -> data stays 8'hA1 during the stall, then 8'hA1, 8'hA2, 8'hA3 complete back-to-back.
REQ-033 waitrequest stuck at 1, then 6 events with DEPTH=4 -> event_ready=0 after the 4th, drop_count=2; after release, exactly 4 writes in order.
REQ-034 300 events while stalled -> drop_count saturates at 255 and does not wrap.
REQ-035 Reset pulsed low in WRITE mid-stall -> avm_m0_write=0 asynchronously; after release, no write until a new event arrives.
REQ-036 FIFO full and a completion on the same cycle as a new event -> the new event is dropped (drop_count+1) and occupancy becomes DEPTH-1.

Source files
------------

// File: rtl/mtl_pkg.sv
// Shared types and widths for the event-to-Avalon master.
package mtl_pkg;

    localparam int EVENT_W    = 8;
    localparam int DROP_CNT_W = 8;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_e;

endpackage

// File: rtl/mtl_event_fifo.sv
// Circular event buffer with wrapping pointers and a separate occupancy counter.
// head_next lets the master reload its write data on the same edge it pops.
module mtl_event_fifo #(
    parameter int DEPTH   = 4,
    parameter int EVENT_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [EVENT_W-1:0]      push_data,
    input  logic                    pop,
    output logic [EVENT_W-1:0]      head,
    output logic [EVENT_W-1:0]      head_next,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [EVENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;

    assign head      = mem_q[rd_ptr_q];
    assign head_next = mem_q[rd_ptr_q + PTR_W'(1)];
    assign full      = (count_q == FULL_COUNT);
    assign empty     = (count_q == '0);
    assign count     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/mtl_event_master.sv
// Buffers one-cycle event strobes and forwards each code as a single Avalon-MM write.
// Overflowing events are dropped and counted with a saturating counter.
module mtl_event_master
    import mtl_pkg::*;
#(
    parameter int   DEPTH       = 4,
    parameter logic TARGET_ADDR = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  event_valid,
    input  logic [EVENT_W-1:0]    event_code,
    output logic                  event_ready,
    output logic                  avm_m0_write,
    output logic                  avm_m0_address,
    output logic [EVENT_W-1:0]    avm_m0_writedata,
    input  logic                  avm_m0_waitrequest,
    output logic [DROP_CNT_W-1:0] drop_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    state_e                state_q, state_d;
    logic                  write_q, write_d;
    logic                  addr_q, addr_d;
    logic [EVENT_W-1:0]    wdata_q, wdata_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [EVENT_W-1:0]    fifo_head;
    logic [EVENT_W-1:0]    fifo_head_next;
    logic [CNT_W-1:0]      fifo_count;
    logic                  complete;

    // Fullness is judged before any same-edge pop, so a full FIFO drops even while draining.
    assign fifo_push = event_valid && !fifo_full;
    assign complete  = (state_q == S_WRITE) && !avm_m0_waitrequest;
    assign fifo_pop  = complete;

    mtl_event_fifo #(
        .DEPTH   (DEPTH),
        .EVENT_W (EVENT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (event_code),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .head_next (fifo_head_next),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = TARGET_ADDR;
        wdata_d = wdata_q;
        drop_d  = drop_q;

        if (event_valid && fifo_full && (drop_q != '1)) begin
            drop_d = drop_q + DROP_CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_WRITE;
                    write_d = 1'b1;
                    wdata_d = fifo_head;
                end
            end
            S_WRITE: begin
                // With one entry left, a same-edge push becomes the next head and is bypassed in.
                if (complete) begin
                    if (fifo_count > CNT_W'(1)) begin
                        wdata_d = fifo_head_next;
                    end else if (fifo_push) begin
                        wdata_d = event_code;
                    end else begin
                        state_d = S_IDLE;
                        write_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            write_q <= 1'b0;
            addr_q  <= TARGET_ADDR;
            wdata_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            drop_q  <= drop_d;
        end
    end

    assign event_ready      = !fifo_full;
    assign avm_m0_write     = write_q;
    assign avm_m0_address   = addr_q;
    assign avm_m0_writedata = wdata_q;
    assign drop_count       = drop_q;

endmodule

// File: tb/tb_mtl_event_master.sv
// Bench for mtl_event_master: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mtl_event_master;

    localparam int   DEPTH       = 4;
    localparam logic TARGET_ADDR = 1'b0;

    logic       clk                = 1'b0;
    logic       reset              = 1'b0;
    logic       event_valid        = 1'b0;
    logic [7:0] event_code         = 8'h00;
    logic       avm_m0_waitrequest = 1'b0;
    logic       event_ready;
    logic       avm_m0_write;
    logic       avm_m0_address;
    logic [7:0] avm_m0_writedata;
    logic [7:0] drop_count;

    int total_count = 0;
    int bad_count   = 0;
    bit check_en    = 1'b0;

    // Reference model: pending events (head is the one being written) and write status.
    byte unsigned mq[$];
    bit           m_active = 1'b0;
    logic [7:0]   m_data   = 8'h00;
    int           m_drop   = 0;

    always #5 clk = ~clk;

    mtl_event_master #(
        .DEPTH       (DEPTH),
        .TARGET_ADDR (TARGET_ADDR)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .event_valid        (event_valid),
        .event_code         (event_code),
        .event_ready        (event_ready),
        .avm_m0_write       (avm_m0_write),
        .avm_m0_address     (avm_m0_address),
        .avm_m0_writedata   (avm_m0_writedata),
        .avm_m0_waitrequest (avm_m0_waitrequest),
        .drop_count         (drop_count)
    );

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] required);
        total_count++;
        if (actual !== required) begin
            bad_count++;
            $display("[TB] FAIL %s at %0t: actual=%0h required=%0h", name, $time, actual, required);
        end
    endtask

    // Drives inputs for one cycle and returns just after the edge that sampled them.
    task automatic apply_stimulus(input logic v, input logic [7:0] c, input logic w);
        event_valid        = v;
        event_code         = c;
        avm_m0_waitrequest = w;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset              = 1'b0;
        event_valid        = 1'b0;
        event_code         = 8'h00;
        avm_m0_waitrequest = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_write", 32'(avm_m0_write), 32'd0);
        check_output("rst_wdata", 32'(avm_m0_writedata), 32'd0);
        check_output("rst_addr", 32'(avm_m0_address), 32'(TARGET_ADDR));
        check_output("rst_ready", 32'(event_ready), 32'd1);
        check_output("rst_drop", 32'(drop_count), 32'd0);
        reset = 1'b1;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_active = 1'b0;
            m_data   = 8'h00;
            m_drop   = 0;
        end else begin
            int sz_before;
            bit full_now;
            bit comp;
            sz_before = mq.size();
            full_now  = (sz_before == DEPTH);
            comp      = m_active && !avm_m0_waitrequest;
            if (event_valid && full_now && m_drop < 255) m_drop++;
            if (comp) void'(mq.pop_front());
            if (event_valid && !full_now) mq.push_back(event_code);
            if (m_active) begin
                if (comp) begin
                    if (mq.size() > 0) m_data = mq[0];
                    else m_active = 1'b0;
                end
            end else if (sz_before > 0) begin
                m_active = 1'b1;
                m_data   = mq[0];
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check_output("m_write", 32'(avm_m0_write), 32'(m_active));
            if (m_active) check_output("m_wdata", 32'(avm_m0_writedata), 32'(m_data));
            check_output("m_addr", 32'(avm_m0_address), 32'(TARGET_ADDR));
            check_output("m_ready", 32'(event_ready), 32'(mq.size() != DEPTH));
            check_output("m_drop", 32'(drop_count), 32'(m_drop));
        end
    end

    initial begin
        do_reset();
        check_en = 1'b1;

        // Single event, no stall.
        apply_stimulus(1'b1, 8'h01, 1'b0);
        check_output("single_wait_latency", 32'(avm_m0_write), 32'd0);
        apply_stimulus(1'b0, 8'h00, 1'b0);
        check_output("single_write", 32'(avm_m0_write), 32'd1);
        check_output("single_data", 32'(avm_m0_writedata), 32'h01);
        check_output("single_addr", 32'(avm_m0_address), 32'd0);
        apply_stimulus(1'b0, 8'h00, 1'b0);
        check_output("single_pulse_end", 32'(avm_m0_write), 32'd0);
        repeat (2) apply_stimulus(1'b0, 8'h00, 1'b0);
        check_output("single_no_dup", 32'(avm_m0_write), 32'd0);

        // Three events with a three-cycle stall on the first write.
        do_reset();
        apply_stimulus(1'b1, 8'hA1, 1'b0);
        apply_stimulus(1'b1, 8'hA2, 1'b1);
        check_output("stall_first", 32'(avm_m0_writedata), 32'hA1);
        apply_stimulus(1'b1, 8'hA3, 1'b1);
        check_output("stall_hold1", 32'(avm_m0_writedata), 32'hA1);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("stall_hold2", 32'(avm_m0_writedata), 32'hA1);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("stall_hold3", 32'(avm_m0_writedata), 32'hA1);
        apply_stimulus(1'b0, 8'h00, 1'b0);
        check_output("b2b_a2_write", 32'(avm_m0_write), 32'd1);
        check_output("b2b_a2", 32'(avm_m0_writedata), 32'hA2);
        apply_stimulus(1'b0, 8'h00, 1'b0);
        check_output("b2b_a3", 32'(avm_m0_writedata), 32'hA3);
        apply_stimulus(1'b0, 8'h00, 1'b0);
        check_output("b2b_idle", 32'(avm_m0_write), 32'd0);

        // Overflow while stalled: six events into four slots.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1'b1, 8'hB0 + 8'(i), 1'b1);
            if (i == 3) check_output("ovf_ready_low", 32'(event_ready), 32'd0);
        end
        check_output("ovf_drop2", 32'(drop_count), 32'd2);
        for (int i = 0; i < 4; i++) begin
            check_output("ovf_order", 32'(avm_m0_writedata), 32'hB0 + 32'(i));
            apply_stimulus(1'b0, 8'h00, 1'b0);
        end
        check_output("ovf_done", 32'(avm_m0_write), 32'd0);

        // Full FIFO, completion and a new event on the same edge.
        do_reset();
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 8'hD0 + 8'(i), 1'b1);
        check_output("fc_full", 32'(event_ready), 32'd0);
        apply_stimulus(1'b1, 8'hD4, 1'b0);
        check_output("fc_drop", 32'(drop_count), 32'd1);
        check_output("fc_ready", 32'(event_ready), 32'd1);
        check_output("fc_next", 32'(avm_m0_writedata), 32'hD1);
        repeat (4) apply_stimulus(1'b0, 8'h00, 1'b0);
        check_output("fc_drained", 32'(avm_m0_write), 32'd0);

        // Saturation of the drop counter.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            apply_stimulus(1'b1, 8'(i), 1'b1);
            if (i == 257) check_output("sat_254", 32'(drop_count), 32'd254);
        end
        check_output("sat_255", 32'(drop_count), 32'd255);
        repeat (6) apply_stimulus(1'b0, 8'h00, 1'b0);
        check_output("sat_hold", 32'(drop_count), 32'd255);

        // Asynchronous reset mid-stall.
        do_reset();
        apply_stimulus(1'b1, 8'hE0, 1'b0);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("ar_before", 32'(avm_m0_write), 32'd1);
        #2 reset = 1'b0;
        #1;
        check_output("ar_async_write", 32'(avm_m0_write), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) begin
            apply_stimulus(1'b0, 8'h00, 1'b0);
            check_output("ar_no_replay", 32'(avm_m0_write), 32'd0);
        end
        apply_stimulus(1'b1, 8'hE5, 1'b0);
        apply_stimulus(1'b0, 8'h00, 1'b0);
        check_output("ar_new_write", 32'(avm_m0_writedata), 32'hE5);

        // Randomised traffic under light, medium and heavy stalling.
        do_reset();
        for (int seg = 0; seg < 3; seg++) begin
            for (int i = 0; i < 150; i++) begin
                logic v;
                logic w;
                v = ($urandom_range(3, 0) != 0);
                case (seg)
                    0:       w = ($urandom_range(7, 0) == 0);
                    1:       w = ($urandom_range(1, 0) == 0);
                    default: w = ($urandom_range(7, 0) != 0);
                endcase
                apply_stimulus(v, 8'($urandom()), w);
            end
        end
        repeat (20) apply_stimulus(1'b0, 8'h00, 1'b0);
        check_output("rnd_drained_write", 32'(avm_m0_write), 32'd0);
        check_output("rnd_drained_ready", 32'(event_ready), 32'd1);

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total_count, bad_count);
        $finish;
    end

endmodule
